// File: rtl/nn_cfg_axil_master_pkg.sv
// Shared definitions for the NN configuration AXI4-Lite master.
package nn_cfg_axil_master_pkg;

  localparam int unsigned C_M_AXI_DATA_WIDTH = 32;
  localparam int unsigned C_M_AXI_ADDR_WIDTH = 5;
  localparam int unsigned C_M_AXI_STRB_WIDTH = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned LAYER_W            = 8;
  localparam int unsigned NEURON_W           = 16;

  // Slave register map (byte offsets)
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] REG_WEIGHT = 5'h00;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] REG_BIAS   = 5'h04;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] REG_OUTPUT = 5'h08;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] REG_LAYER  = 5'h10;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] REG_NEURON = 5'h14;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    CMD_WEIGHT = 2'b00,
    CMD_BIAS   = 2'b01,
    CMD_READ   = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_W,
    ST_WAIT_B,
    ST_ISSUE_AR,
    ST_WAIT_R,
    ST_RSP
  } state_e;

  typedef enum logic [1:0] {
    STEP_LAYER  = 2'd0,
    STEP_NEURON = 2'd1,
    STEP_DATA   = 2'd2
  } step_e;

  // One AXI-Lite write: target offset and 32-bit payload
  typedef struct packed {
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/nn_cfg_axil_master_if.sv
// AXI4-Lite bus between the configuration master and the accelerator register file.
interface nn_cfg_axil_master_if;
  import nn_cfg_axil_master_pkg::*;

  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr;
  logic [2:0]                    awprot;
  logic                          awvalid;
  logic                          awready;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata;
  logic [C_M_AXI_STRB_WIDTH-1:0] wstrb;
  logic                          wvalid;
  logic                          wready;
  logic [1:0]                    bresp;
  logic                          bvalid;
  logic                          bready;
  logic [C_M_AXI_ADDR_WIDTH-1:0] araddr;
  logic [2:0]                    arprot;
  logic                          arvalid;
  logic                          arready;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                    rresp;
  logic                          rvalid;
  logic                          rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/nn_cfg_axil_master_axil_wr_channel.sv
// Single AXI-Lite write transaction: AW and W issued together, accepted independently, then B.
module axil_wr_channel
  import nn_cfg_axil_master_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  wr_req_t                       i_req,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] o_awaddr,
  output logic                          o_awvalid,
  input  logic                          i_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_wdata,
  output logic                          o_wvalid,
  input  logic                          i_wready,
  input  logic                          i_bvalid,
  output logic                          o_bready,
  output logic                          o_accept_c,
  output logic                          o_done_c
);

  logic [C_M_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;
  logic                          r_awvalid;
  logic                          r_wvalid;
  logic                          r_bready;
  logic                          r_aw_done;
  logic                          r_w_done;
  logic                          w_aw_hs;
  logic                          w_w_hs;

  assign w_aw_hs    = r_awvalid & i_awready;
  assign w_w_hs     = r_wvalid & i_wready;
  // Both halves accepted, counting one that completes in this very cycle
  assign o_accept_c = (r_awvalid | r_wvalid) & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
  assign o_done_c   = r_bready & i_bvalid;

  assign o_awaddr  = r_awaddr;
  assign o_awvalid = r_awvalid;
  assign o_wdata   = r_wdata;
  assign o_wvalid  = r_wvalid;
  assign o_bready  = r_bready;

  // Launch, per-channel accept tracking and B-phase handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (i_start) begin
      r_awaddr  <= i_req.addr;
      r_wdata   <= i_req.data;
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
      if (o_accept_c) begin
        r_bready <= 1'b1;
      end else if (o_done_c) begin
        r_bready <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nn_cfg_axil_master.sv
// AXI4-Lite master turning weight/bias/read commands into accelerator register accesses.
module nn_cfg_axil_master
  import nn_cfg_axil_master_pkg::*;
(
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_type,
  input  logic [LAYER_W-1:0]            cmd_layer,
  input  logic [NEURON_W-1:0]           cmd_neuron,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_data,
  output logic                          busy,
  output logic                          err,
  nn_cfg_axil_master_if.master          m_axi
);

  state_e                        r_state;
  state_e                        w_state_nxt;
  cmd_type_e                     r_cmd_type;
  logic [LAYER_W-1:0]            r_layer;
  logic [NEURON_W-1:0]           r_neuron;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_data;
  logic                          r_need_neuron;
  step_e                         r_step;
  logic [LAYER_W-1:0]            r_layer_q;
  logic                          r_layer_vld;
  logic [NEURON_W-1:0]           r_neuron_q;
  logic                          r_neuron_vld;
  logic                          r_cmd_ready;
  logic                          r_busy;
  logic                          r_err;
  logic                          r_arvalid;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_araddr;
  logic                          r_rready;
  logic                          r_rsp_valid;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_rsp_data;

  cmd_type_e                     w_cmd_type;
  logic                          w_cmd_fire;
  logic                          w_need_layer;
  logic                          w_need_neuron;
  logic                          w_wr_start;
  step_e                         w_wr_step;
  wr_req_t                       w_wr_req;
  cmd_type_e                     w_src_type;
  logic [LAYER_W-1:0]            w_src_layer;
  logic [NEURON_W-1:0]           w_src_neuron;
  logic [C_M_AXI_DATA_WIDTH-1:0] w_src_data;
  logic                          w_accept_c;
  logic                          w_bdone_c;
  logic                          w_b_ok;
  logic [C_M_AXI_ADDR_WIDTH-1:0] w_awaddr;
  logic [C_M_AXI_DATA_WIDTH-1:0] w_wdata;
  logic                          w_awvalid;
  logic                          w_wvalid;
  logic                          w_bready;

  assign w_cmd_type    = cmd_type_e'(cmd_type);
  assign w_cmd_fire    = cmd_valid & r_cmd_ready;
  assign w_need_layer  = !r_layer_vld || (cmd_layer != r_layer_q);
  assign w_need_neuron = !r_neuron_vld || (cmd_neuron != r_neuron_q);
  assign w_b_ok        = (m_axi.bresp == RESP_OKAY);

  // Payload source: live command fields on capture, stored fields for later steps
  assign w_src_type   = (r_state == ST_IDLE) ? w_cmd_type : r_cmd_type;
  assign w_src_layer  = (r_state == ST_IDLE) ? cmd_layer  : r_layer;
  assign w_src_neuron = (r_state == ST_IDLE) ? cmd_neuron : r_neuron;
  assign w_src_data   = (r_state == ST_IDLE) ? cmd_data   : r_data;

  // Next-state and write-launch decode
  always_comb begin
    w_state_nxt = r_state;
    w_wr_start  = 1'b0;
    w_wr_step   = STEP_DATA;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          if ((w_cmd_type == CMD_WEIGHT) || (w_cmd_type == CMD_BIAS)) begin
            w_state_nxt = ST_ISSUE_W;
            w_wr_start  = 1'b1;
            w_wr_step   = w_need_layer ? STEP_LAYER : (w_need_neuron ? STEP_NEURON : STEP_DATA);
          end else if (w_cmd_type == CMD_READ) begin
            w_state_nxt = ST_ISSUE_AR;
          end
        end
      end
      ST_ISSUE_W: begin
        if (w_accept_c) w_state_nxt = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        if (w_bdone_c) begin
          if (!w_b_ok || (r_step == STEP_DATA)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_ISSUE_W;
            w_wr_start  = 1'b1;
            w_wr_step   = ((r_step == STEP_LAYER) && r_need_neuron) ? STEP_NEURON : STEP_DATA;
          end
        end
      end
      ST_ISSUE_AR: begin
        if (m_axi.arready) w_state_nxt = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        if (m_axi.rvalid) w_state_nxt = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address/data for the write step being launched
  always_comb begin
    w_wr_req = '0;
    unique case (w_wr_step)
      STEP_LAYER: begin
        w_wr_req.addr = REG_LAYER;
        w_wr_req.data = C_M_AXI_DATA_WIDTH'(w_src_layer);
      end
      STEP_NEURON: begin
        w_wr_req.addr = REG_NEURON;
        w_wr_req.data = C_M_AXI_DATA_WIDTH'(w_src_neuron);
      end
      default: begin
        w_wr_req.addr = (w_src_type == CMD_BIAS) ? REG_BIAS : REG_WEIGHT;
        w_wr_req.data = w_src_data;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) r_state <= ST_IDLE;
    else                r_state <= w_state_nxt;
  end

  // Command capture and current write step
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_cmd_type    <= CMD_WEIGHT;
      r_layer       <= '0;
      r_neuron      <= '0;
      r_data        <= '0;
      r_need_neuron <= 1'b0;
      r_step        <= STEP_LAYER;
    end else begin
      if (w_cmd_fire) begin
        r_cmd_type    <= w_cmd_type;
        r_layer       <= cmd_layer;
        r_neuron      <= cmd_neuron;
        r_data        <= cmd_data;
        r_need_neuron <= w_need_neuron;
      end
      if (w_wr_start) r_step <= w_wr_step;
    end
  end

  // Layer/neuron cache: refreshed on OKAY, invalidated when the slave rejects the write
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_layer_q    <= '0;
      r_layer_vld  <= 1'b0;
      r_neuron_q   <= '0;
      r_neuron_vld <= 1'b0;
    end else if (w_bdone_c) begin
      if (r_step == STEP_LAYER) begin
        r_layer_vld <= w_b_ok;
        if (w_b_ok) r_layer_q <= r_layer;
      end
      if (r_step == STEP_NEURON) begin
        r_neuron_vld <= w_b_ok;
        if (w_b_ok) r_neuron_q <= r_neuron;
      end
    end
  end

  // Handshake/status flags and sticky error
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      if ((w_cmd_fire && (w_cmd_type == CMD_RSVD)) ||
          (w_bdone_c && !w_b_ok) ||
          (r_rready && m_axi.rvalid && (m_axi.rresp != RESP_OKAY))) begin
        r_err <= 1'b1;
      end
    end
  end

  // Read path: AR issue, R capture, response hold
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_ISSUE_AR)) begin
        r_arvalid <= 1'b1;
        r_araddr  <= REG_OUTPUT;
      end else if (r_arvalid && m_axi.arready) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end
      if (r_rready && m_axi.rvalid) begin
        r_rready    <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= m_axi.rdata;
      end
      if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
    end
  end

  axil_wr_channel u_wr (
    .clk        (s_axi_aclk),
    .rst_n      (s_axi_aresetn),
    .i_start    (w_wr_start),
    .i_req      (w_wr_req),
    .o_awaddr   (w_awaddr),
    .o_awvalid  (w_awvalid),
    .i_awready  (m_axi.awready),
    .o_wdata    (w_wdata),
    .o_wvalid   (w_wvalid),
    .i_wready   (m_axi.wready),
    .i_bvalid   (m_axi.bvalid),
    .o_bready   (w_bready),
    .o_accept_c (w_accept_c),
    .o_done_c   (w_bdone_c)
  );

  assign m_axi.awaddr  = w_awaddr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = w_awvalid;
  assign m_axi.wdata   = w_wdata;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = w_wvalid;
  assign m_axi.bready  = w_bready;
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_nn_cfg_axil_master.sv
// Directed bench for nn_cfg_axil_master with a configurable AXI-Lite slave model.
module tb_nn_cfg_axil_master;
  import nn_cfg_axil_master_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_type;
  logic [LAYER_W-1:0]  cmd_layer;
  logic [NEURON_W-1:0] cmd_neuron;
  logic [31:0]         cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic                busy;
  logic                err;

  nn_cfg_axil_master_if axil();

  nn_cfg_axil_master dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_type      (cmd_type),
    .cmd_layer     (cmd_layer),
    .cmd_neuron    (cmd_neuron),
    .cmd_data      (cmd_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .err           (err),
    .m_axi         (axil)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int          aw_dly   = 0;
  logic        b_hold   = 1'b0;
  logic        inj_err  = 1'b0;
  logic [31:0] rd_val   = 32'h0;
  int          aw_cnt   = 0;
  logic        aw_have, w_have, b_pend;
  logic [4:0]  aw_addr_q;
  logic [31:0] w_data_q;
  logic [1:0]  b_resp_q;
  logic        s_bvalid, s_rvalid;
  logic [1:0]  s_bresp;
  logic [31:0] s_rdata;
  logic [4:0]  ar_seen;
  logic        aw_hs, w_hs;
  logic [4:0]  cur_addr;
  logic [31:0] cur_data;
  logic [4:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          b_cnt = 0, w_first_cnt = 0, stab_err = 0, proto_err = 0;
  logic        p_aw_stall, p_ar_stall;
  logic [4:0]  p_awaddr, p_araddr;
  logic [31:0] p_wdata;

  assign axil.awready = axil.awvalid && (aw_cnt >= aw_dly);
  assign axil.wready  = 1'b1;
  assign axil.arready = 1'b1;
  assign axil.bvalid  = s_bvalid;
  assign axil.bresp   = s_bresp;
  assign axil.rvalid  = s_rvalid;
  assign axil.rdata   = s_rdata;
  assign axil.rresp   = 2'b00;

  assign aw_hs    = axil.awvalid && axil.awready;
  assign w_hs     = axil.wvalid && axil.wready;
  assign cur_addr = aw_hs ? axil.awaddr : aw_addr_q;
  assign cur_data = w_hs ? axil.wdata : w_data_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; aw_have <= 1'b0; w_have <= 1'b0; b_pend <= 1'b0;
      aw_addr_q <= '0; w_data_q <= '0; b_resp_q <= '0;
      s_bvalid <= 1'b0; s_bresp <= '0; s_rvalid <= 1'b0; s_rdata <= '0;
      p_aw_stall <= 1'b0; p_ar_stall <= 1'b0;
    end else begin
      aw_cnt <= (axil.awvalid && !axil.awready) ? aw_cnt + 1 : 0;
      if (aw_hs) begin aw_have <= 1'b1; aw_addr_q <= axil.awaddr; end
      if (w_hs)  begin w_have  <= 1'b1; w_data_q  <= axil.wdata;  end
      if ((aw_have || aw_hs) && (w_have || w_hs)) begin
        wr_addr_q.push_back(cur_addr);
        wr_data_q.push_back(cur_data);
        aw_have <= 1'b0;
        w_have  <= 1'b0;
        if (b_hold) begin
          b_pend   <= 1'b1;
          b_resp_q <= (inj_err && cur_addr == 5'h10) ? 2'b10 : 2'b00;
        end else begin
          s_bvalid <= 1'b1;
          s_bresp  <= (inj_err && cur_addr == 5'h10) ? 2'b10 : 2'b00;
        end
      end
      if (b_pend && !b_hold) begin s_bvalid <= 1'b1; s_bresp <= b_resp_q; b_pend <= 1'b0; end
      if (s_bvalid && axil.bready) begin s_bvalid <= 1'b0; b_cnt <= b_cnt + 1; end
      if (axil.arvalid && axil.arready) begin
        ar_seen <= axil.araddr; s_rvalid <= 1'b1; s_rdata <= rd_val;
      end
      if (s_rvalid && axil.rready) s_rvalid <= 1'b0;
      // protocol monitors
      if (w_hs && axil.awvalid && !axil.awready) w_first_cnt <= w_first_cnt + 1;
      if (axil.bready && (axil.awvalid || axil.wvalid)) proto_err <= proto_err + 1;
      if ((axil.awvalid != axil.wvalid) && !aw_have && !w_have) proto_err <= proto_err + 1;
      if (p_aw_stall && (!axil.awvalid || axil.awaddr != p_awaddr || axil.wdata != p_wdata))
        stab_err <= stab_err + 1;
      if (p_ar_stall && (!axil.arvalid || axil.araddr != p_araddr)) stab_err <= stab_err + 1;
      p_aw_stall <= axil.awvalid && !axil.awready;
      p_ar_stall <= axil.arvalid && !axil.arready;
      p_awaddr   <= axil.awaddr;
      p_wdata    <= axil.wdata;
      p_araddr   <= axil.araddr;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [4:0] a, input logic [31:0] d);
    if (idx < wr_addr_q.size()) begin
      check({tag, "_addr"}, 32'(wr_addr_q[idx]), 32'(a));
      check({tag, "_data"}, wr_data_q[idx], d);
    end else begin
      check({tag, "_missing"}, 32'(wr_addr_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [7:0] l, input logic [15:0] n,
                          input logic [31:0] d);
    int cnt = 0;
    cmd_valid = 1'b1; cmd_type = t; cmd_layer = l; cmd_neuron = n; cmd_data = d;
    while (!cmd_ready && cnt < 50) begin @(negedge clk); cnt++; end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int cyc);
    cyc = 0;
    while (!cmd_ready && cyc < 200) begin @(negedge clk); cyc++; end
    check(tag, 32'(cmd_ready), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valids"}, 32'({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready}), 32'd0);
    check({tag, "_status"}, 32'({cmd_ready, rsp_valid, busy, err}), 32'd0);
    check({tag, "_addr"}, 32'({axil.awaddr, axil.araddr}), 32'd0);
    check({tag, "_wdata"}, axil.wdata, 32'd0);
    check({tag, "_rspdata"}, rsp_data, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, bbase, fbase, cyc;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_type = '0; cmd_layer = '0;
    cmd_neuron = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check_outputs_zero("rst");
    check("rst_fixed", 32'({axil.awprot, axil.arprot, axil.wstrb}), 32'h00F);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // weight command, cold cache: LAYER, NEURON, WEIGHT
    base = wr_addr_q.size(); bbase = b_cnt;
    send_cmd(2'b00, 8'd1, 16'd3, 32'h0000_0A5A);
    wait_idle("wgt_done", cyc);
    check("wgt_latency", 32'(cyc), 32'd6);
    check("wgt_nwr", 32'(wr_addr_q.size() - base), 32'd3);
    check_wr("wgt_w0", base + 0, 5'h10, 32'd1);
    check_wr("wgt_w1", base + 1, 5'h14, 32'd3);
    check_wr("wgt_w2", base + 2, 5'h00, 32'h0000_0A5A);
    check("wgt_nb", 32'(b_cnt - bbase), 32'd3);
    check("wgt_busy", 32'({busy, err}), 32'd0);

    // bias command, warm cache: single BIAS write
    base = wr_addr_q.size();
    send_cmd(2'b01, 8'd1, 16'd3, 32'h0000_0100);
    wait_idle("bias_done", cyc);
    check("bias_latency", 32'(cyc), 32'd2);
    check("bias_nwr", 32'(wr_addr_q.size() - base), 32'd1);
    check_wr("bias_w0", base, 5'h04, 32'h0000_0100);

    // awready delayed 3 cycles: W accepted first, one B per write
    aw_dly = 3;
    base = wr_addr_q.size(); bbase = b_cnt; fbase = w_first_cnt;
    send_cmd(2'b00, 8'd2, 16'd3, 32'h0000_1234);
    wait_idle("dly_done", cyc);
    check("dly_nwr", 32'(wr_addr_q.size() - base), 32'd2);
    check_wr("dly_w0", base + 0, 5'h10, 32'd2);
    check_wr("dly_w1", base + 1, 5'h00, 32'h0000_1234);
    check("dly_nb", 32'(b_cnt - bbase), 32'd2);
    check("dly_wfirst", 32'(w_first_cnt - fbase), 32'd2);
    check("dly_stable", 32'(stab_err), 32'd0);
    aw_dly = 0;

    // read command with rsp_ready held low for 4 cycles
    rd_val = 32'h0000_0007;
    base = wr_addr_q.size();
    send_cmd(2'b10, 8'd0, 16'd0, 32'd0);
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin @(negedge clk); cyc++; end
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_araddr", 32'(ar_seen), 32'h08);
    for (int i = 0; i < 4; i++) begin
      check("rd_hold_valid", 32'(rsp_valid), 32'd1);
      check("rd_hold_data", rsp_data, 32'h0000_0007);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rd_released", 32'({rsp_valid, cmd_ready, busy}), 32'b010);
    check("rd_nwr", 32'(wr_addr_q.size() - base), 32'd0);
    check("rd_err", 32'(err), 32'd0);

    // SLVERR on the LAYER write abandons the command
    inj_err = 1'b1;
    base = wr_addr_q.size();
    send_cmd(2'b00, 8'd5, 16'd3, 32'h0000_0055);
    wait_idle("berr_done", cyc);
    inj_err = 1'b0;
    check("berr_err", 32'(err), 32'd1);
    check("berr_nwr", 32'(wr_addr_q.size() - base), 32'd1);
    check_wr("berr_w0", base, 5'h10, 32'd5);
    // same layer again: LAYER must be rewritten, neuron is still cached
    base = wr_addr_q.size();
    send_cmd(2'b00, 8'd5, 16'd3, 32'h0000_0066);
    wait_idle("berr2_done", cyc);
    check("berr2_nwr", 32'(wr_addr_q.size() - base), 32'd2);
    check_wr("berr2_w0", base + 0, 5'h10, 32'd5);
    check_wr("berr2_w1", base + 1, 5'h00, 32'h0000_0066);
    check("berr2_err_sticky", 32'(err), 32'd1);

    // reset asserted while waiting for B
    b_hold = 1'b1;
    send_cmd(2'b00, 8'd1, 16'd3, 32'h0000_0077);
    cyc = 0;
    while (!axil.bready && cyc < 50) begin @(negedge clk); cyc++; end
    check("mrst_in_wait_b", 32'(axil.bready), 32'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mrst");
    b_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = wr_addr_q.size();
    send_cmd(2'b00, 8'd1, 16'd3, 32'h0000_0077);
    wait_idle("mrst2_done", cyc);
    check("mrst2_nwr", 32'(wr_addr_q.size() - base), 32'd3);
    check_wr("mrst2_w0", base + 0, 5'h10, 32'd1);
    check_wr("mrst2_w1", base + 1, 5'h14, 32'd3);
    check_wr("mrst2_w2", base + 2, 5'h00, 32'h0000_0077);
    check("mrst2_err", 32'(err), 32'd0);

    // reserved command: dropped, err set, FSM stays idle
    base = wr_addr_q.size();
    send_cmd(2'b11, 8'd9, 16'd9, 32'hDEAD_BEEF);
    check("rsvd_state", 32'({err, busy, cmd_ready}), 32'b101);
    repeat (3) @(negedge clk);
    check("rsvd_nwr", 32'(wr_addr_q.size() - base), 32'd0);
    check("rsvd_no_ar", 32'({axil.arvalid, axil.awvalid}), 32'd0);

    check("proto_err", 32'(proto_err), 32'd0);
    check("stab_err", 32'(stab_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
